// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory req/gnt + rvalid bus between fetch stage and imem
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: fetch PC, imem requests, slot queue, redirect flush
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_f,
    input  logic         br_taken,
    input  logic [31:0]  br_target,
    fetch_unit_if.master imem,
    output logic [31:0]  instruction_f,
    output logic [31:0]  pc_f,
    output logic         valid_f
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      slot_pc    [DEPTH];
    logic [31:0]      slot_instr [DEPTH];
    logic [DEPTH-1:0] slot_filled;
    logic [PW-1:0]    alloc_ptr;
    logic [PW-1:0]    fill_ptr;
    logic [PW-1:0]    read_ptr;
    logic [CW-1:0]    alloc_cnt;
    logic [CW-1:0]    unfilled_cnt;
    logic [CW-1:0]    discard_cnt;

    logic             grant;
    logic             fill;
    logic             drop;
    logic             pop;
    logic [SW-1:0]    occupancy;
    logic [SW-1:0]    redirect_discard;

    // Wrong-path responses still owed by memory keep consuming capacity until they drain.
    assign occupancy = SW'(alloc_cnt) + SW'(discard_cnt);
    assign imem.req  = rst && (occupancy < DEPTH_S) && !br_taken;
    assign imem.addr = fetch_pc;

    assign grant = imem.req && imem.gnt;
    assign drop  = imem.rvalid && (discard_cnt != '0);
    assign fill  = imem.rvalid && (discard_cnt == '0) && (unfilled_cnt != '0);

    assign valid_f       = (alloc_cnt != '0) && slot_filled[read_ptr] && !br_taken;
    assign instruction_f = valid_f ? slot_instr[read_ptr] : NOP_INSTR;
    assign pc_f          = valid_f ? slot_pc[read_ptr] : 32'h0;
    assign pop           = valid_f && !stall_f;

    // Every request not yet answered at the redirect edge becomes a response to throw away.
    assign redirect_discard = SW'(unfilled_cnt) + SW'(discard_cnt) - SW'(drop || fill);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc     <= RESET_PC;
            alloc_ptr    <= '0;
            fill_ptr     <= '0;
            read_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            discard_cnt  <= '0;
            slot_filled  <= '0;
        end else if (br_taken) begin
            fetch_pc     <= {br_target[31:2], 2'b00};
            alloc_ptr    <= '0;
            fill_ptr     <= '0;
            read_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            discard_cnt  <= redirect_discard[CW-1:0];
            slot_filled  <= '0;
        end else begin
            if (grant) begin
                fetch_pc  <= fetch_pc + 32'd4;
                alloc_ptr <= alloc_ptr + PW'(1);
            end
            if (fill) begin
                slot_filled[fill_ptr] <= 1'b1;
                fill_ptr              <= fill_ptr + PW'(1);
            end
            if (drop) begin
                discard_cnt <= discard_cnt - CW'(1);
            end
            if (pop) begin
                slot_filled[read_ptr] <= 1'b0;
                read_ptr              <= read_ptr + PW'(1);
            end
            alloc_cnt    <= alloc_cnt + CW'(grant) - CW'(pop);
            unfilled_cnt <= unfilled_cnt + CW'(grant) - CW'(fill);
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            slot_pc[alloc_ptr] <= fetch_pc;
        end
        if (fill) begin
            slot_instr[fill_ptr] <= imem.rdata;
        end
    end
endmodule
